// File: rtl/fuzzy_job_seq_if.sv
// Job / threshold-table / MMIO / result signal bundle for fuzzy_job_seq.
// master: the job source and MMIO peripheral side. slave: the sequencer.
interface fuzzy_job_seq_if;
  logic       job_valid;
  logic       job_ready;
  logic [7:0] job_T;
  logic [7:0] job_dT;
  logic       job_reg_mode;
  logic       job_dt_mode;
  logic       cfg_reload;
  logic [4:0] thr_idx;
  logic [7:0] thr_data;
  logic       cs;
  logic       rd;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_G;
  logic       res_timeout;
  logic       busy;

  modport master (
    output job_valid, job_T, job_dT, job_reg_mode, job_dt_mode, cfg_reload,
           thr_data, rdata, res_ready,
    input  job_ready, thr_idx, cs, rd, wr, addr, wdata,
           res_valid, res_G, res_timeout, busy
  );

  modport slave (
    input  job_valid, job_T, job_dT, job_reg_mode, job_dt_mode, cfg_reload,
           thr_data, rdata, res_ready,
    output job_ready, thr_idx, cs, rd, wr, addr, wdata,
           res_valid, res_G, res_timeout, busy
  );
endinterface

// File: rtl/fuzzy_job_seq.sv
// Fuzzy controller job sequencer: accepts a job, optionally reloads the
// 24-entry threshold table over MMIO, programs T/dT/CTRL, polls status and
// returns the captured G value.
// Optional feature macro: FJS_TIMEOUT_EN -- bounds POLL to TIMEOUT_CYC reads
// and reports res_timeout=1 when the bound expires.
module fuzzy_job_seq #(
  parameter int TIMEOUT_CYC = 1000
) (
  input logic           clk,
  input logic           rst_n,
  fuzzy_job_seq_if.slave bus
);

  localparam logic [7:0] A_STAT = 8'h00;
  localparam logic [7:0] A_CTRL = 8'h01;
  localparam logic [7:0] A_T    = 8'h02;
  localparam logic [7:0] A_DT   = 8'h03;
  localparam logic [7:0] A_G    = 8'h04;
  localparam logic [7:0] A_THR  = 8'h10;
  localparam logic [4:0] THR_LAST = 5'd23;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_THR, S_WR_INIT, S_WR_T, S_WR_DT,
    S_WR_CTRL, S_WAIT, S_POLL, S_READ_G, S_RESP
  } state_t;

  typedef struct packed {
    logic [7:0] t;
    logic [7:0] dt;
    logic       reg_mode;
    logic       dt_mode;
  } job_t;

  state_t     state, nxt;
  job_t       job_q;
  logic [4:0] cnt, cnt_d;
  logic       reload_pend;
  logic [7:0] res_g_q;
  logic       res_to_q;
  logic       capture_g;
  logic       timeout_hit;

  logic       cs_c, rd_c, wr_c;
  logic [7:0] addr_c, wdata_c;
  logic [4:0] thr_idx_c;

`ifdef FJS_TIMEOUT_EN
  localparam int PW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [PW-1:0] poll_q;

  // Counts POLL cycles; restarts from 0 on every entry into POLL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               poll_q <= '0;
    else if (state != S_POLL) poll_q <= '0;
    else                      poll_q <= poll_q + 1'b1;
  end
`endif

  // State and sequencing counter (table index / wait count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
    end
  end

  // Next state and bus strobes; the bus is idle unless a state drives it.
  always_comb begin
    nxt         = state;
    cnt_d       = cnt;
    cs_c        = 1'b0;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    addr_c      = 8'h00;
    wdata_c     = 8'h00;
    thr_idx_c   = 5'd0;
    capture_g   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.job_valid)
          nxt = (reload_pend || bus.cfg_reload) ? S_LOAD_THR : S_WR_T;
      end
      S_LOAD_THR: begin
        cs_c      = 1'b1;
        wr_c      = 1'b1;
        addr_c    = A_THR + {3'b000, cnt};
        wdata_c   = bus.thr_data;
        thr_idx_c = cnt;
        if (cnt == THR_LAST) begin
          cnt_d = '0;
          nxt   = S_WR_INIT;
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      S_WR_INIT: begin
        cs_c    = 1'b1;
        wr_c    = 1'b1;
        addr_c  = A_CTRL;
        wdata_c = {4'b0000, 1'b1, job_q.dt_mode, job_q.reg_mode, 1'b0};
        nxt     = S_WR_T;
      end
      S_WR_T: begin
        cs_c    = 1'b1;
        wr_c    = 1'b1;
        addr_c  = A_T;
        wdata_c = job_q.t;
        nxt     = job_q.dt_mode ? S_WR_CTRL : S_WR_DT;
      end
      S_WR_DT: begin
        cs_c    = 1'b1;
        wr_c    = 1'b1;
        addr_c  = A_DT;
        wdata_c = job_q.dt;
        nxt     = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        cs_c    = 1'b1;
        wr_c    = 1'b1;
        addr_c  = A_CTRL;
        wdata_c = {4'b0000, 1'b0, job_q.dt_mode, job_q.reg_mode, 1'b1};
        cnt_d   = '0;
        nxt     = S_WAIT;
      end
      S_WAIT: begin
        // two dead cycles so the peripheral drops the previous result's valid
        if (cnt == 5'd1) begin
          cnt_d = '0;
          nxt   = S_POLL;
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      S_POLL: begin
        cs_c   = 1'b1;
        rd_c   = 1'b1;
        addr_c = A_STAT;
        if (bus.rdata[0]) begin
          nxt = S_READ_G;
        end
`ifdef FJS_TIMEOUT_EN
        else if (poll_q == PW'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          nxt         = S_RESP;
        end
`endif
      end
      S_READ_G: begin
        cs_c      = 1'b1;
        rd_c      = 1'b1;
        addr_c    = A_G;
        capture_g = 1'b1;
        nxt       = S_RESP;
      end
      S_RESP: begin
        if (bus.res_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Latch job fields on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                job_q <= '0;
    else if (state == S_IDLE && bus.job_valid) job_q <= '{t: bus.job_T, dt: bus.job_dT,
                                                          reg_mode: bus.job_reg_mode,
                                                          dt_mode: bus.job_dt_mode};
  end

  // Sticky reload request; a pulse coinciding with WR_INIT wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  reload_pend <= 1'b1;
    else if (bus.cfg_reload)     reload_pend <= 1'b1;
    else if (state == S_WR_INIT) reload_pend <= 1'b0;
  end

  // Result capture; held through RESP until the next capture or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_g_q  <= 8'h00;
      res_to_q <= 1'b0;
    end else if (capture_g) begin
      res_g_q  <= bus.rdata;
      res_to_q <= 1'b0;
    end else if (timeout_hit) begin
      res_g_q  <= 8'h00;
      res_to_q <= 1'b1;
    end
  end

  assign bus.job_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.res_valid   = (state == S_RESP);
  assign bus.res_G       = res_g_q;
`ifdef FJS_TIMEOUT_EN
  assign bus.res_timeout = res_to_q;
`else
  assign bus.res_timeout = 1'b0;
`endif
  assign bus.cs          = cs_c;
  assign bus.rd          = rd_c;
  assign bus.wr          = wr_c;
  assign bus.addr        = addr_c;
  assign bus.wdata       = wdata_c;
  assign bus.thr_idx     = thr_idx_c;

`ifndef FJS_TIMEOUT_EN
  // Timeout state exists only with the feature; keep the flop tidy otherwise.
  logic unused_res_to;
  assign unused_res_to = res_to_q ^ timeout_hit;
`endif

endmodule

// File: tb/tb_fuzzy_job_seq.sv
// Scoreboard bench for fuzzy_job_seq: expected MMIO writes and results are
// queued when each job is driven and popped as the DUT produces them.
module tb_fuzzy_job_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fuzzy_job_seq_if bus();
  fuzzy_job_seq #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [15:0] wq[$];
  logic [8:0]  rq[$];
  bit          reload_m = 1'b1;
  logic [7:0]  g_val = 8'h00;
  int          poll_need = 1;
  int          poll_cnt = 0;
  int          polls_tot = 0;
  int          g_reads = 0;
  int          poll_entry = 0;
  bit          prev_poll = 1'b0;
  int          acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] thr_fn(input logic [4:0] i);
    return (({3'b000, i} * 8'd7) + 8'd3) ^ 8'hA5;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: status goes valid on the poll_need-th read after START.
  always @(posedge clk) begin
    if (bus.cs && bus.wr && bus.addr == 8'h01 && bus.wdata[0]) poll_cnt <= 0;
    else if (bus.cs && bus.rd && bus.addr == 8'h00)          poll_cnt <= poll_cnt + 1;
  end

  always_comb begin
    bus.rdata    = 8'h00;
    bus.thr_data = thr_fn(bus.thr_idx);
    if (bus.rd && bus.addr == 8'h00)
      bus.rdata = {7'b1010101, (poll_cnt >= poll_need - 1)};
    else if (bus.rd && bus.addr == 8'h04)
      bus.rdata = g_val;
  end

  // Bus and result monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cs) begin
        check("strobe_1hot", 32'(bus.rd ^ bus.wr), 1);
        if (bus.wr) begin
          check("wr_pending", 32'(wq.size() > 0), 1);
          if (wq.size() > 0) check("wr", {bus.addr, bus.wdata}, wq.pop_front());
        end
        if (bus.rd) begin
          check("rd_addr", 32'(bus.addr == 8'h00 || bus.addr == 8'h04), 1);
          if (bus.addr == 8'h00) begin
            polls_tot++;
            if (!prev_poll) poll_entry = cyc;
          end else begin
            g_reads++;
          end
        end
      end else begin
        check("bus_idle", {bus.rd, bus.wr, bus.addr, bus.wdata}, 0);
      end
      prev_poll = bus.cs && bus.rd && bus.addr == 8'h00;
      if (bus.res_valid && bus.res_ready) begin
        check("res_pending", 32'(rq.size() > 0), 1);
        if (rq.size() > 0) check("res", {bus.res_timeout, bus.res_G}, rq.pop_front());
      end
    end
  end

  task automatic send_job(input logic [7:0] t, input logic [7:0] dt, input logic regm,
                          input logic dtm, input logic [7:0] g, input int pn,
                          input bit exp_to, output int extra);
    g_val     = g;
    poll_need = pn;
    extra     = (dtm ? 0 : 1) + (reload_m ? 25 : 0);
    if (reload_m) begin
      for (int i = 0; i < 24; i++) wq.push_back({8'h10 + 8'(i), thr_fn(5'(i))});
      wq.push_back({8'h01, 4'b0000, 1'b1, dtm, regm, 1'b0});
      reload_m = 1'b0;
    end
    wq.push_back({8'h02, t});
    if (!dtm) wq.push_back({8'h03, dt});
    wq.push_back({8'h01, 4'b0000, 1'b0, dtm, regm, 1'b1});
    rq.push_back(exp_to ? 9'h100 : {1'b0, g});
    bus.job_T        = t;
    bus.job_dT       = dt;
    bus.job_reg_mode = regm;
    bus.job_dt_mode  = dtm;
    bus.job_valid    = 1'b1;
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!bus.job_ready && k < 200);
      if (k >= 200) check("accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(input int exp_poll_ofs, input int exp_res_ofs);
    int k = 0;
    do begin @(negedge clk); k++; end while (!bus.res_valid && k < 500);
    if (k >= 500) check("res_valid_timeout", 0, 1);
    check("lat_first_poll", 32'(poll_entry - acc_cyc), 32'(exp_poll_ofs));
    check("lat_res_valid", 32'(cyc - acc_cyc), 32'(exp_res_ofs));
  endtask

  task automatic drain();
    int k = 0;
    while (rq.size() > 0 && k < 50) begin @(posedge clk); #1; k++; end
    check("res_drained", 32'(rq.size()), 0);
  endtask

  initial begin
    int ex, p0, g0;
    bus.job_valid = 1'b0; bus.job_T = 8'h00; bus.job_dT = 8'h00;
    bus.job_reg_mode = 1'b0; bus.job_dt_mode = 1'b0;
    bus.cfg_reload = 1'b0; bus.res_ready = 1'b1;
    #12;
    check("rst_strobes", {bus.cs, bus.rd, bus.wr, bus.addr, bus.wdata}, 0);
    check("rst_res", {bus.res_valid, bus.res_timeout, bus.res_G}, 0);
    check("rst_busy_idx", {bus.busy, bus.thr_idx}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("job_ready_after_rst", 32'(bus.job_ready), 1);

    // Job 1: reload from reset, dt_mode=1, valid on third poll.
    send_job(8'h20, 8'h00, 1'b1, 1'b1, 8'h32, 3, 1'b0, ex);
    wait_valid(4 + ex, 5 + ex + 3);
    drain();

    // Job 2: no reload, dt_mode=0.
    p0 = polls_tot;
    send_job(8'hF0, 8'h05, 1'b1, 1'b0, 8'h41, 1, 1'b0, ex);
    wait_valid(4 + ex, 5 + ex + 1);
    drain();
    check("job2_polls", 32'(polls_tot - p0), 1);

    // Job 3: reload pulse while polling affects only the next job.
    send_job(8'h7F, 8'h80, 1'b0, 1'b0, 8'd100, 6, 1'b0, ex);
    begin
      int k = 0;
      do begin @(negedge clk); k++; end
        while (!(bus.cs && bus.rd && bus.addr == 8'h00) && k < 100);
      if (k >= 100) check("poll_timeout", 0, 1);
    end
    @(posedge clk); #1; bus.cfg_reload = 1'b1;
    @(posedge clk); #1; bus.cfg_reload = 1'b0;
    reload_m = 1'b1;
    wait_valid(4 + ex, 5 + ex + 6);
    drain();

    // Job 4: reload, result held with res_ready low.
    bus.res_ready = 1'b0;
    send_job(8'h01, 8'hFF, 1'b0, 1'b1, 8'h00, 2, 1'b0, ex);
    wait_valid(4 + ex, 5 + ex + 2);
    for (int i = 0; i < 10; i++) begin
      check("hold_state", {bus.res_valid, bus.job_ready, bus.busy, bus.res_G}, {3'b101, 8'h00});
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    drain();

`ifdef FJS_TIMEOUT_EN
    // Timeout: status never valid, exactly TIMEOUT_CYC polls, no G read.
    p0 = polls_tot; g0 = g_reads;
    send_job(8'h10, 8'h00, 1'b0, 1'b1, 8'h77, 1000, 1'b1, ex);
    wait_valid(4 + ex, 4 + ex + 8);
    drain();
    check("to_polls", 32'(polls_tot - p0), 8);
    check("to_g_reads", 32'(g_reads - g0), 0);
`else
    g0 = g_reads;
    p0 = polls_tot;
`endif

    // Reset during LOAD_THR at index 10.
    @(posedge clk); #1; bus.cfg_reload = 1'b1;
    @(posedge clk); #1; bus.cfg_reload = 1'b0;
    reload_m = 1'b1;
    send_job(8'h33, 8'h00, 1'b0, 1'b1, 8'h11, 1, 1'b0, ex);
    begin
      int k = 0;
      while (bus.thr_idx != 5'd10 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) check("idx10_timeout", 0, 1);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", {bus.cs, bus.wr, bus.rd, bus.thr_idx}, 0);
    check("midrst_idle", {bus.busy, bus.job_ready, bus.res_valid}, 3'b010);
    wq.delete(); rq.delete();
    reload_m = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("job_ready_after_midrst", 32'(bus.job_ready), 1);

    // Job 6: must reload from index 0.
    send_job(8'h44, 8'h12, 1'b1, 1'b0, 8'h63, 2, 1'b0, ex);
    wait_valid(4 + ex, 5 + ex + 2);
    drain();
    check("wq_empty", 32'(wq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
